hazard_sched: RTL and testbench

//  Issue scheduler between instruction fetch and DC_Block in the 8-bit MIPS pipeline.

---
 rtl/hazard_sched.sv | 161 ++++++++++++++++
 tb/tb_hazard_sched.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sched.sv
// rtl/hazard_sched.sv - issue scheduler with load-use stall and operand forwarding selects
//
// Purpose:
//   Sits between instruction fetch and DC_Block in the 8-bit MIPS pipeline.
//   It keeps a 2-deep scoreboard of in-flight destination registers. From that
//   scoreboard it derives registered forwarding selects for each issued
//   instruction. On a load-use hazard it stalls fetch and issues a bubble.
//   On a taken branch (flush) it squashes the instruction being issued.
//
// Instruction word:
//   op[23:19] rd[18:14] rs1[13:9] rs2[8:4]
//   Immediate-format ops (op[4:3]==IMM_PFX) carry imm in [8:1]; rs2 is not a source.
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous active-low reset
//   ins_if     in   24     instruction from fetch, held while pc_en=0
//   ins_valid  in   1      ins_if is a real instruction (0 -> bubble issued)
//   flush      in   1      squash the instruction being issued this cycle
//   ins_dc     out  24     registered instruction to DC_Block
//   fwd_sel_A  out  2      rs1 source: 00 regfile, 01 dist-1 result, 10 dist-2 result
//   fwd_sel_B  out  2      rs2 source, same encoding
//   pc_en      out  1      fetch advance enable (0 = hold PC and ins_if)
//   stall_cnt  out  CNT_W  saturating count of load-use stall cycles since reset

module hazard_sched #(
   parameter logic [4:0] LD_OP   = 5'b10100,
   parameter logic [4:0] ST_OP   = 5'b10101,
   parameter logic [4:0] NOP_OP  = 5'b11111,
   parameter logic [1:0] IMM_PFX = 2'b01,
   parameter int         CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [23:0]      ins_if,
   input  logic             ins_valid,
   input  logic             flush,
   output logic [23:0]      ins_dc,
   output logic [1:0]       fwd_sel_A,
   output logic [1:0]       fwd_sel_B,
   output logic             pc_en,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [23:0] BUBBLE = {NOP_OP, 19'b0};
   localparam logic [1:0]  SEL_RF = 2'b00;
   localparam logic [1:0]  SEL_D1 = 2'b01;
   localparam logic [1:0]  SEL_D2 = 2'b10;

   // Scoreboard: slot1 describes the instruction currently in ins_dc,
   // slot2 the one issued the cycle before it. Only slot1 needs the load flag,
   // because a load two stages ahead has already produced its data.
   logic [4:0] s1_rd;
   logic       s1_we;
   logic       s1_ld;
   logic [4:0] s2_rd;
   logic       s2_we;

   // Decode of the instruction being offered for issue.
   logic [4:0] op;
   logic [4:0] rd;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic       rs2_src;
   logic       new_we;
   logic       new_ld;

   assign op      = ins_if[23:19];
   assign rd      = ins_if[18:14];
   assign rs1     = ins_if[13:9];
   assign rs2     = ins_if[8:4];
   assign rs2_src = (op[4:3] != IMM_PFX);
   assign new_we  = (op != ST_OP) && (op != NOP_OP);
   assign new_ld  = (op == LD_OP);

   // Forwarding source for one operand. R0 is hardwired, so it is never
   // forwarded; the nearer producer wins when both slots hold the register.
   function automatic logic [1:0] fwd_src(
      input logic [4:0] rs,
      input logic       is_src,
      input logic [4:0] a_rd,
      input logic       a_we,
      input logic       a_ld,
      input logic [4:0] b_rd,
      input logic       b_we
   );
      logic [1:0] sel;
      sel = SEL_RF;
      if (is_src && (rs != 5'd0)) begin
         if (a_we && !a_ld && (rs == a_rd))
            sel = SEL_D1;
         else if (b_we && (rs == b_rd))
            sel = SEL_D2;
      end
      return sel;
   endfunction

   logic       use_a;
   logic       use_b;
   logic       stall;
   logic [1:0] sel_a;
   logic [1:0] sel_b;

   always_comb begin
      use_a = 1'b0;
      use_b = 1'b0;
      stall = 1'b0;
      sel_a = SEL_RF;
      sel_b = SEL_RF;
      if (ins_valid) begin
         // A source depending on the load directly ahead cannot be forwarded
         // yet; one bubble moves the load into slot2 where its data is ready.
         use_a = (rs1 != 5'd0) && s1_we && s1_ld && (rs1 == s1_rd);
         use_b = rs2_src && (rs2 != 5'd0) && s1_we && s1_ld && (rs2 == s1_rd);
         stall = use_a || use_b;
         sel_a = fwd_src(rs1, 1'b1, s1_rd, s1_we, s1_ld, s2_rd, s2_we);
         sel_b = fwd_src(rs2, rs2_src, s1_rd, s1_we, s1_ld, s2_rd, s2_we);
      end
   end

   // A flush redirects fetch anyway, so the hold on the PC is released.
   assign pc_en = ~stall | flush;

   always_ff @(posedge clk) begin
      if (!reset) begin
         ins_dc    <= BUBBLE;
         fwd_sel_A <= SEL_RF;
         fwd_sel_B <= SEL_RF;
         stall_cnt <= '0;
         s1_rd     <= 5'd0;
         s1_we     <= 1'b0;
         s1_ld     <= 1'b0;
         s2_rd     <= 5'd0;
         s2_we     <= 1'b0;
      end else begin
         // The scoreboard always ages by one slot, bubble or not.
         s2_rd <= s1_rd;
         s2_we <= s1_we;
         if (flush || stall || !ins_valid) begin
            ins_dc    <= BUBBLE;
            fwd_sel_A <= SEL_RF;
            fwd_sel_B <= SEL_RF;
            s1_rd     <= 5'd0;
            s1_we     <= 1'b0;
            s1_ld     <= 1'b0;
            // Only genuine load-use stalls are counted; a flush takes
            // precedence and the stall never happens.
            if (!flush && stall && (stall_cnt != {CNT_W{1'b1}}))
               stall_cnt <= stall_cnt + CNT_W'(1);
         end else begin
            ins_dc    <= ins_if;
            fwd_sel_A <= sel_a;
            fwd_sel_B <= sel_b;
            s1_rd     <= rd;
            s1_we     <= new_we;
            s1_ld     <= new_ld;
         end
      end
   end

endmodule

// File: tb/tb_hazard_sched.sv
// tb/tb_hazard_sched.sv - self-checking bench for hazard_sched
module tb_hazard_sched;

   localparam logic [4:0]  LD  = 5'b10100;
   localparam logic [4:0]  ST  = 5'b10101;
   localparam logic [4:0]  ADD = 5'b00000;
   localparam logic [4:0]  OPX = 5'b00100;
   localparam logic [4:0]  IMM = 5'b01101;
   localparam logic [23:0] BUB = 24'hF80000;

   logic        clk = 1'b0;
   logic        reset;
   logic [23:0] ins_if;
   logic        ins_valid;
   logic        flush;
   logic [23:0] ins_dc;
   logic [1:0]  fwd_sel_A;
   logic [1:0]  fwd_sel_B;
   logic        pc_en;
   logic [7:0]  stall_cnt;

   always #5 clk = ~clk;

   hazard_sched dut (
      .clk       (clk),
      .reset     (reset),
      .ins_if    (ins_if),
      .ins_valid (ins_valid),
      .flush     (flush),
      .ins_dc    (ins_dc),
      .fwd_sel_A (fwd_sel_A),
      .fwd_sel_B (fwd_sel_B),
      .pc_en     (pc_en),
      .stall_cnt (stall_cnt)
   );

   typedef struct packed {
      logic [23:0] ins;
      logic        v;
      logic        f;
      logic        pc;
      logic [23:0] dc;
      logic [1:0]  a;
      logic [1:0]  b;
   } step_t;

   step_t       steps[$];
   logic [27:0] sb[$];
   logic [27:0] exp_out;
   int          checks   = 0;
   int          failures = 0;

   function automatic logic [23:0] r(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
      return {op, rd, rs1, rs2, 4'b0};
   endfunction

   function automatic step_t st(input logic [23:0] ins, input logic v, input logic f,
                                input logic pc, input logic [23:0] dc,
                                input logic [1:0] a, input logic [1:0] b);
      step_t s;
      s.ins = ins; s.v = v; s.f = f; s.pc = pc; s.dc = dc; s.a = a; s.b = b;
      return s;
   endfunction

   task automatic do_reset();
      reset = 1'b0; ins_valid = 1'b1; flush = 1'b0; ins_if = r(ADD, 5'd1, 5'd2, 5'd3);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0; ins_valid = 1'b1; flush = 1'b1; ins_if = r(LD, 5'd4, 5'd0, 5'd0);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (ins_dc !== BUB) begin
         failures++; $display("FAIL reset_ins_dc got %h want %h", ins_dc, BUB);
      end
      checks++;
      if ({fwd_sel_A, fwd_sel_B} !== 4'b0000) begin
         failures++; $display("FAIL reset_sel got %b%b want 0000", fwd_sel_A, fwd_sel_B);
      end
      checks++;
      if (pc_en !== 1'b1) begin
         failures++; $display("FAIL reset_pc_en got %b want 1", pc_en);
      end
      checks++;
      if (stall_cnt !== 8'h00) begin
         failures++; $display("FAIL reset_stall_cnt got %h want 00", stall_cnt);
      end
      reset = 1'b1; flush = 1'b0;
   endtask

   task automatic test_forward();
      do_reset();
      steps = {};
      steps.push_back(st(r(ADD,5'd1,5'd2,5'd3), 1, 0, 1, r(ADD,5'd1,5'd2,5'd3), 2'b00, 2'b00));
      steps.push_back(st(r(ADD,5'd4,5'd1,5'd1), 1, 0, 1, r(ADD,5'd4,5'd1,5'd1), 2'b01, 2'b01));
      steps.push_back(st(r(ADD,5'd1,5'd2,5'd3), 1, 0, 1, r(ADD,5'd1,5'd2,5'd3), 2'b00, 2'b00));
      steps.push_back(st(r(ADD,5'd7,5'd2,5'd3), 1, 0, 1, r(ADD,5'd7,5'd2,5'd3), 2'b00, 2'b00));
      steps.push_back(st(r(ADD,5'd4,5'd1,5'd1), 1, 0, 1, r(ADD,5'd4,5'd1,5'd1), 2'b10, 2'b10));
      // store writes nothing: a following reader of its rd field gets regfile
      steps.push_back(st(r(ST, 5'd9,5'd4,5'd7),  1, 0, 1, r(ST, 5'd9,5'd4,5'd7),  2'b01, 2'b10));
      steps.push_back(st(r(ADD,5'd2,5'd9,5'd4), 1, 0, 1, r(ADD,5'd2,5'd9,5'd4), 2'b00, 2'b10));
      foreach (steps[i]) begin
         ins_if = steps[i].ins; ins_valid = steps[i].v; flush = steps[i].f;
         #1;
         checks++;
         if (pc_en !== steps[i].pc) begin
            failures++; $display("FAIL fwd_pc_en step %0d got %b want %b", i, pc_en, steps[i].pc);
         end
         sb.push_back({steps[i].dc, steps[i].a, steps[i].b});
         @(posedge clk); #1;
         exp_out = sb.pop_front();
         checks++;
         if ({ins_dc, fwd_sel_A, fwd_sel_B} !== exp_out) begin
            failures++;
            $display("FAIL fwd_out step %0d got %h/%b/%b want %h/%b/%b", i, ins_dc, fwd_sel_A,
                     fwd_sel_B, exp_out[27:4], exp_out[3:2], exp_out[1:0]);
         end
      end
   endtask

   task automatic test_load_use();
      logic [23:0] x;
      logic [23:0] y;
      logic [23:0] im;
      logic [23:0] im2;
      x   = r(OPX, 5'd5, 5'd1, 5'd4);
      y   = r(ADD, 5'd5, 5'd4, 5'd4);
      im  = {IMM, 5'd6, 5'd4, 8'd5, 1'b0};
      im2 = {IMM, 5'd6, 5'd5, 5'd4, 4'b0};
      do_reset();
      steps = {};
      steps.push_back(st(r(LD,5'd4,5'd0,5'd0), 1, 0, 1, r(LD,5'd4,5'd0,5'd0), 2'b00, 2'b00));
      steps.push_back(st(x,  1, 0, 0, BUB, 2'b00, 2'b00));
      steps.push_back(st(x,  1, 0, 1, x,   2'b00, 2'b10));
      steps.push_back(st(r(LD,5'd4,5'd0,5'd0), 1, 0, 1, r(LD,5'd4,5'd0,5'd0), 2'b00, 2'b00));
      steps.push_back(st(y,  1, 0, 0, BUB, 2'b00, 2'b00));
      steps.push_back(st(y,  1, 0, 1, y,   2'b10, 2'b10));
      steps.push_back(st(r(LD,5'd4,5'd0,5'd0), 1, 0, 1, r(LD,5'd4,5'd0,5'd0), 2'b00, 2'b00));
      steps.push_back(st(im, 1, 0, 0, BUB, 2'b00, 2'b00));
      steps.push_back(st(im, 1, 0, 1, im,  2'b10, 2'b00));
      steps.push_back(st(r(LD,5'd4,5'd0,5'd0), 1, 0, 1, r(LD,5'd4,5'd0,5'd0), 2'b00, 2'b00));
      steps.push_back(st(im2, 1, 0, 1, im2, 2'b00, 2'b00));
      foreach (steps[i]) begin
         ins_if = steps[i].ins; ins_valid = steps[i].v; flush = steps[i].f;
         #1;
         checks++;
         if (pc_en !== steps[i].pc) begin
            failures++; $display("FAIL ldu_pc_en step %0d got %b want %b", i, pc_en, steps[i].pc);
         end
         sb.push_back({steps[i].dc, steps[i].a, steps[i].b});
         @(posedge clk); #1;
         exp_out = sb.pop_front();
         checks++;
         if ({ins_dc, fwd_sel_A, fwd_sel_B} !== exp_out) begin
            failures++;
            $display("FAIL ldu_out step %0d got %h/%b/%b want %h/%b/%b", i, ins_dc, fwd_sel_A,
                     fwd_sel_B, exp_out[27:4], exp_out[3:2], exp_out[1:0]);
         end
      end
      checks++;
      if (stall_cnt !== 8'd3) begin
         failures++; $display("FAIL ldu_stall_cnt got %0d want 3", stall_cnt);
      end
   endtask

   task automatic test_flush_invalid();
      logic [23:0] x;
      logic [23:0] y;
      x = r(OPX, 5'd5, 5'd1, 5'd4);
      y = r(ADD, 5'd6, 5'd4, 5'd4);
      do_reset();
      steps = {};
      steps.push_back(st(r(LD,5'd4,5'd0,5'd0), 1, 0, 1, r(LD,5'd4,5'd0,5'd0), 2'b00, 2'b00));
      steps.push_back(st(x, 1, 1, 1, BUB, 2'b00, 2'b00));
      steps.push_back(st(y, 1, 0, 1, y,   2'b10, 2'b10));
      steps.push_back(st(r(LD,5'd4,5'd0,5'd0), 1, 0, 1, r(LD,5'd4,5'd0,5'd0), 2'b00, 2'b00));
      steps.push_back(st(x, 0, 0, 1, BUB, 2'b00, 2'b00));
      steps.push_back(st(x, 1, 0, 1, x,   2'b00, 2'b10));
      steps.push_back(st(r(ADD,5'd3,5'd5,5'd0), 1, 1, 1, BUB, 2'b00, 2'b00));
      steps.push_back(st(r(ADD,5'd3,5'd5,5'd0), 1, 0, 1, r(ADD,5'd3,5'd5,5'd0), 2'b10, 2'b00));
      foreach (steps[i]) begin
         ins_if = steps[i].ins; ins_valid = steps[i].v; flush = steps[i].f;
         #1;
         checks++;
         if (pc_en !== steps[i].pc) begin
            failures++; $display("FAIL flush_pc_en step %0d got %b want %b", i, pc_en, steps[i].pc);
         end
         sb.push_back({steps[i].dc, steps[i].a, steps[i].b});
         @(posedge clk); #1;
         exp_out = sb.pop_front();
         checks++;
         if ({ins_dc, fwd_sel_A, fwd_sel_B} !== exp_out) begin
            failures++;
            $display("FAIL flush_out step %0d got %h/%b/%b want %h/%b/%b", i, ins_dc, fwd_sel_A,
                     fwd_sel_B, exp_out[27:4], exp_out[3:2], exp_out[1:0]);
         end
      end
      flush = 1'b0;
      checks++;
      if (stall_cnt !== 8'd0) begin
         failures++; $display("FAIL flush_stall_cnt got %0d want 0", stall_cnt);
      end
   endtask

   task automatic test_saturate_r0_reset();
      logic [23:0] x;
      x = r(OPX, 5'd5, 5'd1, 5'd4);
      do_reset();
      for (int i = 0; i < 300; i++) begin
         ins_if = r(LD, 5'd4, 5'd0, 5'd0); ins_valid = 1'b1; flush = 1'b0;
         @(posedge clk); #1;
         ins_if = x;
         repeat (2) @(posedge clk);
         #1;
         if (i == 99) begin
            checks++;
            if (stall_cnt !== 8'd100) begin
               failures++; $display("FAIL sat_cnt_100 got %0d want 100", stall_cnt);
            end
         end
      end
      checks++;
      if (stall_cnt !== 8'hFF) begin
         failures++; $display("FAIL sat_cnt_final got %h want ff", stall_cnt);
      end
      steps = {};
      steps.push_back(st(r(ADD,5'd0,5'd1,5'd2), 1, 0, 1, r(ADD,5'd0,5'd1,5'd2), 2'b00, 2'b00));
      steps.push_back(st(r(ADD,5'd5,5'd0,5'd0), 1, 0, 1, r(ADD,5'd5,5'd0,5'd0), 2'b00, 2'b00));
      steps.push_back(st(r(LD, 5'd0,5'd0,5'd0), 1, 0, 1, r(LD, 5'd0,5'd0,5'd0), 2'b00, 2'b00));
      steps.push_back(st(r(ADD,5'd6,5'd0,5'd0), 1, 0, 1, r(ADD,5'd6,5'd0,5'd0), 2'b00, 2'b00));
      foreach (steps[i]) begin
         ins_if = steps[i].ins; ins_valid = steps[i].v; flush = steps[i].f;
         #1;
         checks++;
         if (pc_en !== steps[i].pc) begin
            failures++; $display("FAIL r0_pc_en step %0d got %b want %b", i, pc_en, steps[i].pc);
         end
         sb.push_back({steps[i].dc, steps[i].a, steps[i].b});
         @(posedge clk); #1;
         exp_out = sb.pop_front();
         checks++;
         if ({ins_dc, fwd_sel_A, fwd_sel_B} !== exp_out) begin
            failures++;
            $display("FAIL r0_out step %0d got %h/%b/%b want %h/%b/%b", i, ins_dc, fwd_sel_A,
                     fwd_sel_B, exp_out[27:4], exp_out[3:2], exp_out[1:0]);
         end
      end
      // reset taken while a load-use stall is pending
      ins_if = r(LD, 5'd4, 5'd0, 5'd0);
      @(posedge clk); #1;
      ins_if = x; #1;
      checks++;
      if (pc_en !== 1'b0) begin
         failures++; $display("FAIL midrst_pre_pc_en got %b want 0", pc_en);
      end
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      checks++;
      if ({ins_dc, fwd_sel_A, fwd_sel_B, stall_cnt} !== {BUB, 4'b0000, 8'h00}) begin
         failures++;
         $display("FAIL midrst_state got %h/%b/%b/%h want %h/00/00/00", ins_dc, fwd_sel_A,
                  fwd_sel_B, stall_cnt, BUB);
      end
      checks++;
      if (pc_en !== 1'b1) begin
         failures++; $display("FAIL midrst_pc_en got %b want 1", pc_en);
      end
      @(posedge clk); #1;
      checks++;
      if ({ins_dc, fwd_sel_A, fwd_sel_B} !== {x, 4'b0000}) begin
         failures++;
         $display("FAIL midrst_issue got %h/%b/%b want %h/00/00", ins_dc, fwd_sel_A, fwd_sel_B, x);
      end
   endtask

   initial begin
      reset = 1'b0; ins_valid = 1'b0; flush = 1'b0; ins_if = 24'h0;
      test_reset();
      test_forward();
      test_load_use();
      test_flush_invalid();
      test_saturate_r0_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout reached without finishing");
      $fatal(1);
   end

endmodule
